// File: rtl/i2c_master_pkg.sv
// Shared definitions for the I2C master sequencer: state encoding,
// state width and the ack/NACK bit levels driven on SDA by the master.
package i2c_master_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE      = 4'd0;
    localparam logic [STATE_W-1:0] ST_START     = 4'd1;
    localparam logic [STATE_W-1:0] ST_WR_ADDR   = 4'd2;
    localparam logic [STATE_W-1:0] ST_RD_ACK    = 4'd3;
    localparam logic [STATE_W-1:0] ST_WR_DATA   = 4'd4;
    localparam logic [STATE_W-1:0] ST_RD_DATA   = 4'd5;
    localparam logic [STATE_W-1:0] ST_WR_ACK    = 4'd6;
    localparam logic [STATE_W-1:0] ST_STOP      = 4'd7;
    localparam logic [STATE_W-1:0] ST_REP_START = 4'd8;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = ST_IDLE,
        START     = ST_START,
        WR_ADDR   = ST_WR_ADDR,
        RD_ACK    = ST_RD_ACK,
        WR_DATA   = ST_WR_DATA,
        RD_DATA   = ST_RD_DATA,
        WR_ACK    = ST_WR_ACK,
        STOP      = ST_STOP,
        REP_START = ST_REP_START
    } state_e;

    // Level the master drives in its own ack slot.
    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;

    // Bit-counter value of the last data bit (bit 0) of a byte.
    localparam logic [7:0] LAST_DATA_BIT = 8'd2;

endpackage

// File: rtl/i2c_repeat_start_timer.sv
// Repeated-start hold-off countdown: loads a start value, counts down one
// per core clock while enabled and sticks at zero instead of wrapping.
module i2c_repeat_start_timer #(
    parameter int PRESCALER_W = 8
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic                   load_i,
    input  logic [PRESCALER_W-1:0] load_value_i,
    input  logic                   dec_i,
    output logic [PRESCALER_W-1:0] count_o,
    output logic                   zero_o
);

    logic [PRESCALER_W-1:0] count_q;
    logic [PRESCALER_W-1:0] count_d;

    // Load has priority; a decrement at zero leaves the count at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - PRESCALER_W'(1);
        end
    end

    // Countdown register, cleared by the synchronised core reset.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/i2c_master_fsm.sv
// I2C master phase sequencer. Walks START, address, ack, data and STOP or
// repeated-start phases, driven by external SCL-phase and bit counters.
module i2c_master_fsm
    import i2c_master_pkg::*;
#(
    parameter int PRESCALER_W = 8
) (
    input  logic                   i2c_core_clock_i,
    input  logic                   reset_bit_n_i,
    input  logic                   enable_i,
    input  logic                   rw_i,
    input  logic                   repeat_start_i,
    input  logic                   sda_i,
    input  logic [PRESCALER_W-1:0] counter_detect_edge_i,
    input  logic [7:0]             counter_data_ack_i,
    input  logic [PRESCALER_W-1:0] prescaler_i,
    output logic                   start_cnt_o,
    output logic                   write_addr_cnt_o,
    output logic                   write_data_cnt_o,
    output logic                   read_data_cnt_o,
    output logic                   write_ack_cnt_o,
    output logic                   read_ack_cnt_o,
    output logic                   stop_cnt_o,
    output logic                   repeat_start_cnt_o,
    output logic [PRESCALER_W-1:0] counter_state_done_time_repeat_start_o,
    output logic                   ack_bit_o,
    output logic                   tx_load_o,
    output logic                   rx_valid_o,
    output logic                   nack_o,
    output logic                   busy_o,
    output logic                   scl_en_o
);

    logic [1:0]             rstSync_q;
    logic                   rstN;

    state_e                 state_q;
    state_e                 state_d;
    logic                   ackBit_q;
    logic                   ackBit_d;
    logic                   txLoad_q;
    logic                   txLoad_d;
    logic                   rxValid_q;
    logic                   rxValid_d;
    logic                   nack_q;
    logic                   nack_d;
    logic                   sclEn_q;
    logic                   sclEn_d;

    logic [PRESCALER_W:0]   sampleTarget;
    logic                   sampleHit;
    logic                   driveHit;
    logic                   lastDataBit;
    logic                   repLoad;
    logic                   repDec;
    logic                   repZero;
    logic [PRESCALER_W-1:0] repLoadValue;

    // Reset asserts at once but is released only after two clean clock edges.
    always_ff @(posedge i2c_core_clock_i or negedge reset_bit_n_i) begin
        if (!reset_bit_n_i) begin
            rstSync_q <= 2'b00;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    assign rstN = rstSync_q[1];

    // The 9-bit compare keeps a zero prescaler from aliasing onto a real count.
    assign sampleTarget = {prescaler_i, 1'b0} - (PRESCALER_W+1)'(1);
    assign sampleHit    = ({1'b0, counter_detect_edge_i} == sampleTarget);
    assign driveHit     = (counter_detect_edge_i == (prescaler_i - PRESCALER_W'(1)));
    assign lastDataBit  = (counter_data_ack_i == LAST_DATA_BIT);

    // Repeated start waits a full SCL period (2 * prescaler core clocks).
    assign repLoadValue = {prescaler_i[PRESCALER_W-2:0], 1'b0};
    assign repLoad      = (state_d == REP_START) && (state_q != REP_START);
    assign repDec       = (state_q == REP_START);

    i2c_repeat_start_timer #(
        .PRESCALER_W (PRESCALER_W)
    ) u_repeat_start_timer (
        .clock_i      (i2c_core_clock_i),
        .reset_n_i    (rstN),
        .load_i       (repLoad),
        .load_value_i (repLoadValue),
        .dec_i        (repDec),
        .count_o      (counter_state_done_time_repeat_start_o),
        .zero_o       (repZero)
    );

    // Next-state logic; pulses are computed here and registered so they line up with the new state.
    always_comb begin
        state_d   = state_q;
        ackBit_d  = ackBit_q;
        txLoad_d  = 1'b0;
        rxValid_d = 1'b0;
        nack_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i && (prescaler_i != '0)) begin
                    state_d = START;
                end
            end
            START: begin
                if (sampleHit) begin
                    state_d = WR_ADDR;
                end
            end
            WR_ADDR: begin
                if (sampleHit && lastDataBit) begin
                    state_d = RD_ACK;
                end
            end
            WR_DATA: begin
                if (sampleHit && lastDataBit) begin
                    state_d  = RD_ACK;
                    ackBit_d = ~(enable_i & ~repeat_start_i);
                end
            end
            RD_DATA: begin
                if (sampleHit && lastDataBit) begin
                    state_d   = WR_ACK;
                    ackBit_d  = ~(enable_i & ~repeat_start_i);
                    rxValid_d = 1'b1;
                end
            end
            RD_ACK: begin
                if (sampleHit) begin
                    if (sda_i) begin
                        state_d = STOP;
                        nack_d  = 1'b1;
                    end else if (repeat_start_i) begin
                        state_d = REP_START;
                    end else if (!enable_i) begin
                        state_d = STOP;
                    end else if (!rw_i) begin
                        state_d  = WR_DATA;
                        txLoad_d = 1'b1;
                    end else begin
                        state_d = RD_DATA;
                    end
                end
            end
            WR_ACK: begin
                if (sampleHit) begin
                    if (repeat_start_i) begin
                        state_d = REP_START;
                    end else if (ackBit_q == NACK_BIT) begin
                        state_d = STOP;
                    end else begin
                        state_d = RD_DATA;
                    end
                end
            end
            STOP: begin
                if (sampleHit) begin
                    state_d = IDLE;
                end
            end
            REP_START: begin
                if (repZero) begin
                    state_d = WR_ADDR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // SCL runs from address entry until the drive point inside STOP, and never while idle.
    always_comb begin
        sclEn_d = sclEn_q;
        if (state_q == IDLE) begin
            sclEn_d = 1'b0;
        end else if ((state_q == STOP) && driveHit) begin
            sclEn_d = 1'b0;
        end
        if ((state_d == WR_ADDR) && (state_q != WR_ADDR)) begin
            sclEn_d = 1'b1;
        end
    end

    // State and output registers; reset drops straight to IDLE with no STOP.
    always_ff @(posedge i2c_core_clock_i or negedge rstN) begin
        if (!rstN) begin
            state_q   <= IDLE;
            ackBit_q  <= NACK_BIT;
            txLoad_q  <= 1'b0;
            rxValid_q <= 1'b0;
            nack_q    <= 1'b0;
            sclEn_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ackBit_q  <= ackBit_d;
            txLoad_q  <= txLoad_d;
            rxValid_q <= rxValid_d;
            nack_q    <= nack_d;
            sclEn_q   <= sclEn_d;
        end
    end

    // One-hot phase strobes decoded from the current state.
    always_comb begin
        start_cnt_o        = 1'b0;
        write_addr_cnt_o   = 1'b0;
        write_data_cnt_o   = 1'b0;
        read_data_cnt_o    = 1'b0;
        write_ack_cnt_o    = 1'b0;
        read_ack_cnt_o     = 1'b0;
        stop_cnt_o         = 1'b0;
        repeat_start_cnt_o = 1'b0;
        case (state_q)
            START:     start_cnt_o        = 1'b1;
            WR_ADDR:   write_addr_cnt_o   = 1'b1;
            WR_DATA:   write_data_cnt_o   = 1'b1;
            RD_DATA:   read_data_cnt_o    = 1'b1;
            WR_ACK:    write_ack_cnt_o    = 1'b1;
            RD_ACK:    read_ack_cnt_o     = 1'b1;
            STOP:      stop_cnt_o         = 1'b1;
            REP_START: repeat_start_cnt_o = 1'b1;
            default:   ;
        endcase
    end

    assign ack_bit_o  = ackBit_q;
    assign tx_load_o  = txLoad_q;
    assign rx_valid_o = rxValid_q;
    assign nack_o     = nack_q;
    assign busy_o     = (state_q != IDLE);
    assign scl_en_o   = sclEn_q;

endmodule

// File: tb/tb_i2c_master_fsm.sv
// Directed bench for i2c_master_fsm at prescaler 4. A small bus model drives
// the SCL-phase and bit counters; phases and pulses are checked in sequence.
module tb_i2c_master_fsm;

    localparam logic [7:0] P_IDLE  = 8'h00;
    localparam logic [7:0] P_START = 8'h80;
    localparam logic [7:0] P_WADDR = 8'h40;
    localparam logic [7:0] P_WDATA = 8'h20;
    localparam logic [7:0] P_RDATA = 8'h10;
    localparam logic [7:0] P_WACK  = 8'h08;
    localparam logic [7:0] P_RACK  = 8'h04;
    localparam logic [7:0] P_STOP  = 8'h02;
    localparam logic [7:0] P_REP   = 8'h01;

    logic       clock;
    logic       reset_bit_n_i;
    logic       enable_i;
    logic       rw_i;
    logic       repeat_start_i;
    logic       sda_i;
    logic [7:0] counter_detect_edge_i;
    logic [7:0] counter_data_ack_i;
    logic [7:0] prescaler_i;
    logic       start_cnt_o;
    logic       write_addr_cnt_o;
    logic       write_data_cnt_o;
    logic       read_data_cnt_o;
    logic       write_ack_cnt_o;
    logic       read_ack_cnt_o;
    logic       stop_cnt_o;
    logic       repeat_start_cnt_o;
    logic [7:0] counter_state_done_time_repeat_start_o;
    logic       ack_bit_o;
    logic       tx_load_o;
    logic       rx_valid_o;
    logic       nack_o;
    logic       busy_o;
    logic       scl_en_o;

    int checks = 0;
    int errors = 0;
    int edgeCnt = 0;
    int bitCnt = 9;
    int txCnt = 0;
    int rxCnt = 0;
    int nackCnt = 0;

    i2c_master_fsm #(.PRESCALER_W(8)) dut (
        .i2c_core_clock_i                       (clock),
        .reset_bit_n_i                          (reset_bit_n_i),
        .enable_i                               (enable_i),
        .rw_i                                   (rw_i),
        .repeat_start_i                         (repeat_start_i),
        .sda_i                                  (sda_i),
        .counter_detect_edge_i                  (counter_detect_edge_i),
        .counter_data_ack_i                     (counter_data_ack_i),
        .prescaler_i                            (prescaler_i),
        .start_cnt_o                            (start_cnt_o),
        .write_addr_cnt_o                       (write_addr_cnt_o),
        .write_data_cnt_o                       (write_data_cnt_o),
        .read_data_cnt_o                        (read_data_cnt_o),
        .write_ack_cnt_o                        (write_ack_cnt_o),
        .read_ack_cnt_o                         (read_ack_cnt_o),
        .stop_cnt_o                             (stop_cnt_o),
        .repeat_start_cnt_o                     (repeat_start_cnt_o),
        .counter_state_done_time_repeat_start_o (counter_state_done_time_repeat_start_o),
        .ack_bit_o                              (ack_bit_o),
        .tx_load_o                              (tx_load_o),
        .rx_valid_o                             (rx_valid_o),
        .nack_o                                 (nack_o),
        .busy_o                                 (busy_o),
        .scl_en_o                               (scl_en_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] phase();
        return {start_cnt_o, write_addr_cnt_o, write_data_cnt_o, read_data_cnt_o,
                write_ack_cnt_o, read_ack_cnt_o, stop_cnt_o, repeat_start_cnt_o};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic rw, input logic rs, input logic sda);
        enable_i       = en;
        rw_i           = rw;
        repeat_start_i = rs;
        sda_i          = sda;
    endtask

    // One core clock; afterwards the external counters advance like the real SCL/bit counters.
    task automatic tick();
        logic busyBefore;
        logic reloadBefore;
        logic sampleBefore;
        busyBefore   = busy_o;
        reloadBefore = !busy_o || start_cnt_o || repeat_start_cnt_o;
        sampleBefore = (edgeCnt == 2 * int'(prescaler_i) - 1);
        @(posedge clock);
        #1;
        txCnt   += int'(tx_load_o);
        rxCnt   += int'(rx_valid_o);
        nackCnt += int'(nack_o);
        if (!busyBefore || sampleBefore) edgeCnt = 0;
        else edgeCnt = edgeCnt + 1;
        if (reloadBefore) bitCnt = 9;
        else if (sampleBefore) bitCnt = (bitCnt == 1) ? 9 : bitCnt - 1;
        counter_detect_edge_i = 8'(edgeCnt);
        counter_data_ack_i    = 8'(bitCnt);
    endtask

    task automatic waitPhase(input string tag, input logic [7:0] expected, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (phase() == expected) break;
            tick();
        end
        checkOutput(tag, 32'(phase()), 32'(expected));
    endtask

    task automatic clearCounts();
        txCnt   = 0;
        rxCnt   = 0;
        nackCnt = 0;
    endtask

    initial begin
        reset_bit_n_i         = 1'b1;
        prescaler_i           = 8'd4;
        counter_detect_edge_i = 8'd0;
        counter_data_ack_i    = 8'd9;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset_bit_n_i = 1'b0;
        repeat (3) tick();

        // Reset values
        checkOutput("rst_phase", 32'(phase()), 32'(P_IDLE));
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_scl", 32'(scl_en_o), 32'd0);
        checkOutput("rst_ackbit", 32'(ack_bit_o), 32'd1);
        checkOutput("rst_count", 32'(counter_state_done_time_repeat_start_o), 32'd0);
        checkOutput("rst_pulses", 32'({tx_load_o, rx_valid_o, nack_o}), 32'd0);
        reset_bit_n_i = 1'b1;
        repeat (3) tick();

        // Single-byte write, enable dropped after the first data byte starts
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitPhase("wr_start", P_START, 4);
        waitPhase("wr_addr", P_WADDR, 20);
        checkOutput("wr_scl_on", 32'(scl_en_o), 32'd1);
        waitPhase("wr_addr_ack", P_RACK, 100);
        waitPhase("wr_data", P_WDATA, 20);
        checkOutput("wr_txload", 32'(tx_load_o), 32'd1);
        enable_i = 1'b0;
        waitPhase("wr_data_ack", P_RACK, 100);
        waitPhase("wr_stop", P_STOP, 20);
        waitPhase("wr_idle", P_IDLE, 20);
        checkOutput("wr_txcount", 32'(txCnt), 32'd1);
        checkOutput("wr_scl_off", 32'(scl_en_o), 32'd0);
        tick();

        // Address NACK: STOP for exactly 8 cycles, no data phase
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        waitPhase("nk_start", P_START, 4);
        waitPhase("nk_addr_ack", P_RACK, 100);
        waitPhase("nk_stop", P_STOP, 20);
        checkOutput("nk_pulse", 32'(nack_o), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (7) tick();
        checkOutput("nk_stop_len", 32'(phase()), 32'(P_STOP));
        checkOutput("nk_scl_off", 32'(scl_en_o), 32'd0);
        tick();
        checkOutput("nk_idle", 32'(phase()), 32'(P_IDLE));
        checkOutput("nk_no_tx", 32'(txCnt), 32'd0);
        checkOutput("nk_count", 32'(nackCnt), 32'd1);
        tick();

        // Two-byte read: master ACKs byte 1, NACKs byte 2
        clearCounts();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        waitPhase("rd_start", P_START, 4);
        waitPhase("rd_addr_ack", P_RACK, 100);
        waitPhase("rd_data1", P_RDATA, 20);
        waitPhase("rd_ack1", P_WACK, 100);
        checkOutput("rd_rxvalid1", 32'(rx_valid_o), 32'd1);
        checkOutput("rd_ackbit1", 32'(ack_bit_o), 32'd0);
        waitPhase("rd_data2", P_RDATA, 20);
        enable_i = 1'b0;
        waitPhase("rd_ack2", P_WACK, 100);
        checkOutput("rd_rxvalid2", 32'(rx_valid_o), 32'd1);
        checkOutput("rd_ackbit2", 32'(ack_bit_o), 32'd1);
        waitPhase("rd_stop", P_STOP, 20);
        waitPhase("rd_idle", P_IDLE, 20);
        checkOutput("rd_rxcount", 32'(rxCnt), 32'd2);
        tick();

        // Repeat start at a data ack, with enable falling on the same boundary
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitPhase("rs_start", P_START, 4);
        waitPhase("rs_data", P_WDATA, 100);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        waitPhase("rs_data_ack", P_RACK, 100);
        waitPhase("rs_rep", P_REP, 20);
        checkOutput("rs_cnt_8", 32'(counter_state_done_time_repeat_start_o), 32'd8);
        for (int k = 7; k >= 0; k--) begin
            tick();
            checkOutput($sformatf("rs_cnt_%0d", k),
                        32'({phase(), counter_state_done_time_repeat_start_o}),
                        32'({P_REP, 8'(k)}));
        end
        tick();
        checkOutput("rs_waddr", 32'(phase()), 32'(P_WADDR));
        checkOutput("rs_cnt_sat", 32'(counter_state_done_time_repeat_start_o), 32'd0);
        repeat_start_i = 1'b0;
        waitPhase("rs_addr_ack", P_RACK, 100);
        waitPhase("rs_stop", P_STOP, 20);
        waitPhase("rs_idle", P_IDLE, 20);
        tick();

        // Reset pulse in the middle of a data byte
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitPhase("ar_start", P_START, 4);
        waitPhase("ar_data", P_WDATA, 100);
        repeat (5) tick();
        reset_bit_n_i = 1'b0;
        #2;
        checkOutput("ar_phase", 32'(phase()), 32'(P_IDLE));
        checkOutput("ar_busy", 32'(busy_o), 32'd0);
        checkOutput("ar_scl", 32'(scl_en_o), 32'd0);
        checkOutput("ar_ackbit", 32'(ack_bit_o), 32'd1);
        checkOutput("ar_pulses", 32'({tx_load_o, rx_valid_o, nack_o}), 32'd0);
        repeat (2) tick();
        reset_bit_n_i = 1'b1;
        waitPhase("ar_restart", P_START, 10);
        enable_i = 1'b0;
        waitPhase("ar_addr", P_WADDR, 20);
        waitPhase("ar_addr_ack", P_RACK, 100);
        waitPhase("ar_stop", P_STOP, 20);
        waitPhase("ar_idle", P_IDLE, 20);
        tick();

        // Zero prescaler must never leave IDLE
        begin
            logic busySeen;
            busySeen    = 1'b0;
            prescaler_i = 8'd0;
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 20; i++) begin
                tick();
                busySeen = busySeen | busy_o;
            end
            checkOutput("p0_busy", 32'(busySeen), 32'd0);
            checkOutput("p0_phase", 32'(phase()), 32'(P_IDLE));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
